pipe_delay_n: RTL and testbench



---
 rtl/pipe_delay_n.sv | 135 +++++++++++++
 tb/tb_pipe_delay_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_delay_n.sv
// pipe_delay_n -- clock-enabled multi-lane delay line with per-stage valid.
//
// Delays a LANES*WIDTH word by DEPTH enabled clock edges. Each stage carries
// one valid bit that is shared by all lanes. The block supports stall (en),
// flush (drops every valid bit), a reset value INIT that is replicated into
// every lane of every stage, and an occupancy count of the valid stages.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset (highest priority)
//   en         in   1 = shift all stages, 0 = hold all stages
//   flush      in   clears all valid bits and the count
//   in_valid   in   qualifies a
//   a          in   LANES*WIDTH input word, lane k = a[k*WIDTH +: WIDTH]
//   y          out  data of the last stage, whether or not it is valid
//   out_valid  out  valid bit of the last stage
//   count      out  number of stages holding valid data (0..DEPTH)
//
// Priority on each posedge: reset > flush > en > hold. A flush does not stop
// the data from shifting when en=1. It only marks every stage invalid.

// One lane of the data path: DEPTH registers of WIDTH bits.
// Valid tracking is done in the parent because all lanes share it.
module pipe_delay_n_lane #(
    parameter int              WIDTH = 8,
    parameter int              DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= INIT;
        end else if (en) begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[DEPTH-1];

endmodule

module pipe_delay_n #(
    parameter int               WIDTH = 8,
    parameter int               LANES = 1,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] a,
    output logic [LANES*WIDTH-1:0] y,
    output logic                   out_valid,
    output logic [CW-1:0]          count
);

    // A zero-depth pipe has no last stage to drive y from.
    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("pipe_delay_n: DEPTH must be >= 1");
        end
    endgenerate

    // Lane views of the flat ports.
    logic [LANES-1:0][WIDTH-1:0] a_lane;
    logic [LANES-1:0][WIDTH-1:0] y_lane;

    assign a_lane = a;
    assign y      = y_lane;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            pipe_delay_n_lane #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .INIT  (INIT)
            ) u_lane (
                .clock (clock),
                .reset (reset),
                .en    (en),
                .d     (a_lane[k]),
                .q     (y_lane[k])
            );
        end
    endgenerate

    // Valid bits. Stage i is vld_pipe[i], and the last stage drives out_valid.
    logic [DEPTH-1:0] vld_pipe;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];

    // The occupancy count is updated incrementally rather than by a popcount
    // tree. One word can enter while another leaves on the same edge, so
    // the count changes by at most one per edge. It stays inside 0..DEPTH
    // because an exit needs a valid last stage, and a full pipe always
    // loses its last stage when a new word enters.
    logic [CW-1:0] cnt, cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (flush)
            cnt_next = '0;
        else if (en)
            cnt_next = cnt + CW'(in_valid) - CW'(vld_pipe[DEPTH-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_next;
    end

    assign count = cnt;

endmodule

// File: tb/tb_pipe_delay_n.sv
// Directed bench for pipe_delay_n. It uses three instances:
//   u1: WIDTH=1, DEPTH=1, LANES=1, INIT=0 for the reset/identity case
//   u3: WIDTH=8, DEPTH=3, LANES=2, INIT=8'hC3 for latency, stall, flush and mid-stream reset
//   u4: WIDTH=8, DEPTH=4, LANES=1, INIT=0 for the full stream
// Inputs change 1 time unit after each posedge, and outputs are sampled there.
module tb_pipe_delay_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // u1
    logic r1, e1, f1, iv1, a1, y1, ov1, c1;
    // u3
    logic        r3, e3, f3, iv3, ov3;
    logic [15:0] a3, y3;
    logic [1:0]  c3;
    // u4
    logic       r4, e4, f4, iv4, ov4;
    logic [7:0] a4, y4;
    logic [2:0] c4;

    pipe_delay_n #(.WIDTH(1), .LANES(1), .DEPTH(1), .INIT(1'b0)) u1 (
        .clock(clock), .reset(r1), .en(e1), .flush(f1), .in_valid(iv1),
        .a(a1), .y(y1), .out_valid(ov1), .count(c1));

    pipe_delay_n #(.WIDTH(8), .LANES(2), .DEPTH(3), .INIT(8'hC3)) u3 (
        .clock(clock), .reset(r3), .en(e3), .flush(f3), .in_valid(iv3),
        .a(a3), .y(y3), .out_valid(ov3), .count(c3));

    pipe_delay_n #(.WIDTH(8), .LANES(1), .DEPTH(4), .INIT(8'h00)) u4 (
        .clock(clock), .reset(r4), .en(e4), .flush(f4), .in_valid(iv4),
        .a(a4), .y(y4), .out_valid(ov4), .count(c4));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        r1 = 1; e1 = 1; f1 = 0; iv1 = 1; a1 = 1;
        r3 = 1; e3 = 1; f3 = 0; iv3 = 1; a3 = 16'hFFFF;
        r4 = 1; e4 = 1; f4 = 0; iv4 = 1; a4 = 8'hFF;
        for (int i = 0; i < 16; i++) tick();
        checks++; if (y1 !== 1'b0) begin failures++; $display("FAIL rst_y1 got=%b exp=0", y1); end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL rst_ov1 got=%b exp=0", ov1); end
        checks++; if (c1 !== 1'b0) begin failures++; $display("FAIL rst_c1 got=%0d exp=0", c1); end
        checks++; if (y3 !== 16'hC3C3) begin failures++; $display("FAIL rst_y3 got=%h exp=c3c3", y3); end
        checks++; if (ov3 !== 1'b0 || c3 !== 2'd0) begin failures++; $display("FAIL rst_v3 got ov=%b c=%0d exp ov=0 c=0", ov3, c3); end
        checks++; if (y4 !== 8'h00 || ov4 !== 1'b0 || c4 !== 3'd0) begin failures++; $display("FAIL rst_u4 got y=%h ov=%b c=%0d exp 00/0/0", y4, ov4, c4); end
    endtask

    // DEPTH=1 acts as a single-bit register: y(t+1) = a(t).
    task automatic test_identity();
        logic [7:0] av = 8'b0110_1001;
        logic [7:0] vv = 8'b1011_0011;
        r1 = 0; a1 = 0; iv1 = 0;
        tick();
        checks++; if (y1 !== 1'b0) begin failures++; $display("FAIL id_first got=%b exp=0", y1); end
        a1 = 1; iv1 = 1;
        tick();
        checks++; if (y1 !== 1'b1 || ov1 !== 1'b1 || c1 !== 1'b1) begin failures++; $display("FAIL id_second got y=%b ov=%b c=%b exp 1/1/1", y1, ov1, c1); end
        for (int i = 0; i < 8; i++) begin
            a1 = av[i]; iv1 = vv[i];
            tick();
            checks++;
            if (y1 !== av[i] || ov1 !== vv[i] || c1 !== vv[i]) begin
                failures++; $display("FAIL id_seq%0d got y=%b ov=%b c=%b exp %b/%b/%b", i, y1, ov1, c1, av[i], vv[i], vv[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic       exp_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] exp_c  [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        r3 = 0; e3 = 1; iv3 = 0; a3 = 16'h0000;
        for (int i = 0; i < 3; i++) tick();
        a3 = 16'hA55A; iv3 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            a3 = 16'h0000; iv3 = 0;
            checks++;
            if (ov3 !== exp_ov[i] || c3 !== exp_c[i]) begin
                failures++; $display("FAIL lat_e%0d got ov=%b c=%0d exp ov=%b c=%0d", i + 1, ov3, c3, exp_ov[i], exp_c[i]);
            end
            if (i == 2) begin
                checks++; if (y3 !== 16'hA55A) begin failures++; $display("FAIL lat_y got=%h exp=a55a", y3); end
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] ey [3] = '{16'h1111, 16'h2222, 16'h0000};
        logic        eo [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0]  ec [3] = '{2'd2, 2'd1, 2'd0};
        e3 = 1; iv3 = 0; a3 = 16'h0000;
        for (int i = 0; i < 3; i++) tick();
        a3 = 16'h1111; iv3 = 1; tick();
        a3 = 16'h2222; iv3 = 1; tick();
        checks++; if (c3 !== 2'd2) begin failures++; $display("FAIL stall_load got c=%0d exp=2", c3); end
        // While stalled, the inputs are deliberately live and must be ignored.
        e3 = 0; a3 = 16'hFFFF; iv3 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (y3 !== 16'h0000 || ov3 !== 1'b0 || c3 !== 2'd2) begin
                failures++; $display("FAIL stall_hold%0d got y=%h ov=%b c=%0d exp 0000/0/2", i, y3, ov3, c3);
            end
        end
        e3 = 1; a3 = 16'h0000; iv3 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (y3 !== ey[i] || ov3 !== eo[i] || c3 !== ec[i]) begin
                failures++; $display("FAIL stall_drain%0d got y=%h ov=%b c=%0d exp %h/%b/%0d", i, y3, ov3, c3, ey[i], eo[i], ec[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [15:0] ey [3] = '{16'h0303, 16'h0404, 16'h0000};
        e3 = 1; f3 = 0;
        iv3 = 1; a3 = 16'h0101; tick();
        a3 = 16'h0202; tick();
        a3 = 16'h0303; tick();
        checks++; if (c3 !== 2'd3 || ov3 !== 1'b1 || y3 !== 16'h0101) begin failures++; $display("FAIL fl_full got c=%0d ov=%b y=%h exp 3/1/0101", c3, ov3, y3); end
        // Flush with en=1: the data still shifts, but every stage is marked invalid.
        f3 = 1; iv3 = 1; a3 = 16'h0404; tick();
        checks++; if (c3 !== 2'd0 || ov3 !== 1'b0 || y3 !== 16'h0202) begin failures++; $display("FAIL fl_edge got c=%0d ov=%b y=%h exp 0/0/0202", c3, ov3, y3); end
        f3 = 0; iv3 = 0; a3 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov3 !== 1'b0 || c3 !== 2'd0 || y3 !== ey[i]) begin
                failures++; $display("FAIL fl_after%0d got ov=%b c=%0d y=%h exp 0/0/%h", i, ov3, c3, y3, ey[i]);
            end
        end
        // Flush with en=0: the data holds and the valid bits clear.
        iv3 = 1; a3 = 16'h0505; tick();
        e3 = 0; f3 = 1; iv3 = 1; tick();
        checks++; if (c3 !== 2'd0 || ov3 !== 1'b0) begin failures++; $display("FAIL fl_noen got c=%0d ov=%b exp 0/0", c3, ov3); end
        e3 = 1; f3 = 0; iv3 = 0; a3 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov3 !== 1'b0 || c3 !== 2'd0) begin failures++; $display("FAIL fl_noen_drain%0d got ov=%b c=%0d exp 0/0", i, ov3, c3); end
            if (i == 1) begin
                checks++; if (y3 !== 16'h0505) begin failures++; $display("FAIL fl_noen_y got=%h exp=0505", y3); end
            end
        end
    endtask

    task automatic test_reset_mid();
        e3 = 1; f3 = 0;
        iv3 = 1; a3 = 16'h0A0A; tick();
        a3 = 16'h0B0B; tick();
        checks++; if (c3 !== 2'd2) begin failures++; $display("FAIL rm_load got c=%0d exp=2", c3); end
        r3 = 1; a3 = 16'h0C0C; tick();
        checks++; if (y3 !== 16'hC3C3 || ov3 !== 1'b0 || c3 !== 2'd0) begin failures++; $display("FAIL rm_edge got y=%h ov=%b c=%0d exp c3c3/0/0", y3, ov3, c3); end
        r3 = 0; iv3 = 0; a3 = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ov3 !== 1'b0 || c3 !== 2'd0) begin failures++; $display("FAIL rm_after%0d got ov=%b c=%0d exp 0/0", i, ov3, c3); end
        end
        checks++; if (y3 !== 16'h0000) begin failures++; $display("FAIL rm_y_end got=%h exp=0000", y3); end
    endtask

    // Stream a = 0,1,2,... with in_valid held high. After edge k the last stage
    // holds the word from edge k-3, and the count saturates at DEPTH.
    task automatic test_stream();
        logic [7:0] exp_y;
        logic       exp_ov;
        logic [2:0] exp_c;
        r4 = 0; e4 = 1; f4 = 0; iv4 = 1;
        for (int k = 0; k < 12; k++) begin
            a4 = 8'(k);
            tick();
            exp_ov = (k >= 3);
            exp_y  = (k >= 3) ? 8'(k - 3) : 8'h00;
            exp_c  = (k >= 3) ? 3'd4 : 3'(k + 1);
            checks++;
            if (y4 !== exp_y || ov4 !== exp_ov || c4 !== exp_c) begin
                failures++; $display("FAIL stream_e%0d got y=%h ov=%b c=%0d exp %h/%b/%0d", k, y4, ov4, c4, exp_y, exp_ov, exp_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_latency();
        test_stall();
        test_flush();
        test_reset_mid();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
